// File: rtl/ci_pkg.sv
// Shared types and constants for the custom-instruction operand sequencer.
package ci_pkg;

    localparam int CI_WIDTH = 32;
    localparam logic [CI_WIDTH-1:0] FP_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } ci_state_e;

    // Operand A and B always travel together as one FIFO entry.
    typedef struct packed {
        logic [CI_WIDTH-1:0] a;
        logic [CI_WIDTH-1:0] b;
    } ci_pair_t;

endpackage

// File: rtl/ci_operand_fifo.sv
// Small operand-pair FIFO with a registered occupancy count.
module ci_operand_fifo
    import ci_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  ci_pair_t               push_data,
    input  logic                   pop,
    output ci_pair_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    ci_pair_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ci_operand_sequencer.sv
// Custom-instruction initiator: queues operand pairs, issues them to a multicycle
// accelerator one at a time, and returns each result (or a timeout value) on a valid/ready port.
module ci_operand_sequencer
    import ci_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter int                  TIMEOUT  = 1024,
    parameter logic [CI_WIDTH-1:0] TO_VALUE = FP_QNAN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CI_WIDTH-1:0]    in_dataa,
    input  logic [CI_WIDTH-1:0]    in_datab,
    output logic                   ci_start,
    output logic [CI_WIDTH-1:0]    ci_dataa,
    output logic [CI_WIDTH-1:0]    ci_datab,
    input  logic [CI_WIDTH-1:0]    ci_result,
    input  logic                   ci_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CI_WIDTH-1:0]    out_result,
    output logic                   out_timeout,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    ci_state_e        state;
    ci_state_e        state_next;
    logic [TIMER_W-1:0] timer;

    ci_pair_t push_pair;
    ci_pair_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_pop;

    logic load_ops;
    logic clear_timer;
    logic inc_timer;
    logic capture_done;
    logic capture_to;

    assign push_pair = {in_dataa, in_datab};
    assign in_ready  = !fifo_full;

    ci_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (push_pair),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Done is checked before the timer, so a completion on the last allowed cycle wins.
    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        load_ops     = 1'b0;
        clear_timer  = 1'b0;
        inc_timer    = 1'b0;
        capture_done = 1'b0;
        capture_to   = 1'b0;
        ci_start     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_ops   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                ci_start    = 1'b1;
                clear_timer = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (ci_done) begin
                    capture_done = 1'b1;
                    state_next   = HOLD;
                end else if (timer == TIMER_LAST) begin
                    capture_to = 1'b1;
                    state_next = HOLD;
                end else begin
                    inc_timer = 1'b1;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ci_dataa    <= '0;
            ci_datab    <= '0;
            timer       <= '0;
            out_result  <= '0;
            out_timeout <= 1'b0;
        end else begin
            if (load_ops) begin
                ci_dataa <= fifo_head.a;
                ci_datab <= fifo_head.b;
            end
            if (clear_timer) begin
                timer <= '0;
            end else if (inc_timer) begin
                timer <= timer + 1'b1;
            end
            if (capture_done) begin
                out_result  <= ci_result;
                out_timeout <= 1'b0;
            end else if (capture_to) begin
                out_result  <= TO_VALUE;
                out_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ci_operand_sequencer.sv
// Bench for ci_operand_sequencer: vector table plus hand sequences, a stub accelerator
// and a scoreboard of expected results and issue-to-result latencies.
module tb_ci_operand_sequencer;
    import ci_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int NV      = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_dataa = '0;
    logic [31:0]   in_datab = '0;
    logic          ci_start;
    logic [31:0]   ci_dataa;
    logic [31:0]   ci_datab;
    logic [31:0]   ci_result = '0;
    logic          ci_done = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_result;
    logic          out_timeout;
    logic          busy;
    logic [CW-1:0] fifo_count;

    ci_operand_sequencer #(
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT),
        .TO_VALUE (32'h7FC00000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dataa    (in_dataa),
        .in_datab    (in_datab),
        .ci_start    (ci_start),
        .ci_dataa    (ci_dataa),
        .ci_datab    (ci_datab),
        .ci_result   (ci_result),
        .ci_done     (ci_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_timeout (out_timeout),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    // lat = cycles after the start cycle at which the stub pulses done; 0 = never.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] res;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic        to;
        int          delay;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] stub_res;
        logic [31:0] exp_res;
        logic        exp_to;
        int          exp_delay;
    } vec_t;

    op_t  op_q[$];
    exp_t exp_q[$];
    vec_t vecs[NV];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  n_starts = 0;
    int  n_outs = 0;
    int  stub_cnt = 0;
    bit  sink_en = 1'b0;
    bit  prev_start = 1'b0;
    bit  prev_ov = 1'b0;
    bit  stub_active = 1'b0;
    op_t cur;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stub accelerator and issue checker.
    always @(negedge clk) begin
        if (reset) begin
            ci_done     = 1'b0;
            ci_result   = '0;
            stub_active = 1'b0;
            prev_start  = 1'b0;
        end else begin
            ci_done   = 1'b0;
            ci_result = 32'hDEADBEEF;
            if (stub_active) begin
                stub_cnt++;
                if (cur.lat != 0 && stub_cnt == cur.lat) begin
                    ci_done   = 1'b1;
                    ci_result = cur.res;
                end
            end
            if (ci_start) begin
                n_starts++;
                check32("start_one_cycle", 32'(prev_start), 32'd0);
                if (op_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got ci_start=1, expected no pending op");
                    stub_active = 1'b0;
                end else begin
                    cur = op_q.pop_front();
                    check32("ci_dataa", ci_dataa, cur.a);
                    check32("ci_datab", ci_datab, cur.b);
                    stub_active = 1'b1;
                    stub_cnt    = 0;
                    start_cyc   = cyc;
                end
            end
            prev_start = ci_start;
        end
    end

    // Result sink and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            out_ready = 1'b0;
            prev_ov   = 1'b0;
        end else begin
            out_ready = sink_en;
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 result=%h, expected none", out_result);
                end else begin
                    check32("result_latency", 32'(cyc - start_cyc), 32'(exp_q[0].delay));
                end
            end
            if (out_valid && sink_en) begin
                n_outs++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check32("out_result", out_result, e.res);
                    check32("out_timeout", 32'(out_timeout), 32'(e.to));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                           input logic [31:0] sres, input logic [31:0] eres,
                           input logic eto, input int edel);
        op_t  o;
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_wait: got in_ready=0 for %0d cycles, expected 1", n);
            return;
        end
        o.a = a; o.b = b; o.lat = lat; o.res = sres;
        e.res = eres; e.to = eto; e.delay = edel;
        op_q.push_back(o);
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_dataa = a;
        in_datab = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || fifo_count != '0 || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || fifo_count != '0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got busy=%0b count=%0d pending=%0d, expected idle and drained",
                     name, busy, fifo_count, exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check32({tag, "_ci_start"}, 32'(ci_start), 32'd0);
        check32({tag, "_ci_dataa"}, ci_dataa, 32'd0);
        check32({tag, "_ci_datab"}, ci_datab, 32'd0);
        check32({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check32({tag, "_out_result"}, out_result, 32'd0);
        check32({tag, "_out_timeout"}, 32'(out_timeout), 32'd0);
        check32({tag, "_busy"}, 32'(busy), 32'd0);
        check32({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        int n;
        int s_starts;
        int s_outs;

        //            a             b             lat stub_res      exp_res       to    delay
        vecs[0] = '{32'h3F800000, 32'h40000000,  5, 32'h40400000, 32'h40400000, 1'b0,  6};
        vecs[1] = '{32'h40400000, 32'h40800000,  1, 32'h40E00000, 32'h40E00000, 1'b0,  2};
        vecs[2] = '{32'hC0000000, 32'h3F000000,  0, 32'h12345678, 32'h7FC00000, 1'b1, 17};
        vecs[3] = '{32'h3F800000, 32'h3F800000,  3, 32'h40000000, 32'h40000000, 1'b0,  4};
        vecs[4] = '{32'h00000000, 32'h80000000, 16, 32'h3F800000, 32'h3F800000, 1'b0, 17};
        vecs[5] = '{32'h7F800000, 32'hFF800000, 15, 32'h7FC00001, 32'h7FC00001, 1'b0, 16};
        vecs[6] = '{32'h41200000, 32'h41A00000, 17, 32'h41F00000, 32'h7FC00000, 1'b1, 17};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Table: single op, timeouts, done/timeout race, done arriving in HOLD.
        sink_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            push_op(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].stub_res,
                    vecs[i].exp_res, vecs[i].exp_to, vecs[i].exp_delay);
        end
        wait_idle("table");
        check32("table_starts", 32'(n_starts), 32'(NV));

        // Back-pressure: stall the first result, then fill the FIFO.
        sink_en = 1'b0;
        push_op(32'h3F800000, 32'h3F800000, 2, 32'h40000000, 32'h40000000, 1'b0, 3);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check32("bp_hold_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            push_op(32'h41000000 + 32'(i), 32'h41800000 + 32'(i), i + 1,
                    32'h42000000 + 32'(i), 32'h42000000 + 32'(i), 1'b0, i + 2);
        end
        check32("bp_full_count", 32'(fifo_count), 32'(DEPTH));
        check32("bp_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_dataa = 32'hBAD0BAD0;
        in_datab = 32'hBAD1BAD1;
        @(negedge clk);
        in_valid = 1'b0;
        check32("bp_ignored_push", 32'(fifo_count), 32'(DEPTH));
        sink_en = 1'b1;
        wait_idle("backpressure");
        check32("bp_final_count", 32'(fifo_count), 32'd0);

        // Simultaneous push and pop while idle with one entry.
        push_op(32'h40A00000, 32'h40C00000, 3, 32'h41300000, 32'h41300000, 1'b0, 4);
        check32("pp_pre_count", 32'(fifo_count), 32'd1);
        check32("pp_pre_busy", 32'(busy), 32'd0);
        push_op(32'h40E00000, 32'h41000000, 2, 32'h41700000, 32'h41700000, 1'b0, 3);
        check32("pp_post_count", 32'(fifo_count), 32'd1);
        check32("pp_post_busy", 32'(busy), 32'd1);
        wait_idle("pushpop");

        // Asynchronous reset while waiting, with two entries queued.
        push_op(32'h3F000000, 32'h3E800000, 0, 32'h0, 32'h7FC00000, 1'b1, 17);
        push_op(32'h3E000000, 32'h3D800000, 3, 32'h11111111, 32'h11111111, 1'b0, 4);
        push_op(32'h3D000000, 32'h3C800000, 3, 32'h22222222, 32'h22222222, 1'b0, 4);
        repeat (2) @(negedge clk);
        check32("rst_pre_busy", 32'(busy), 32'd1);
        check32("rst_pre_count", 32'(fifo_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        op_q.delete();
        exp_q.delete();
        check_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        s_starts = n_starts;
        s_outs   = n_outs;
        repeat (30) @(negedge clk);
        check32("rst_no_start", 32'(n_starts), 32'(s_starts));
        check32("rst_no_out", 32'(n_outs), 32'(s_outs));
        check32("rst_idle_valid", 32'(out_valid), 32'd0);
        push_op(32'h40000000, 32'h40000000, 4, 32'h40800000, 32'h40800000, 1'b0, 5);
        wait_idle("after_reset");
        check32("after_reset_starts", 32'(n_starts), 32'(s_starts + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ci_operand_sequencer.md
Name: ci_operand_sequencer

Overview:
- Initiator side of the custom-instruction handshake (clk/start/dataa/datab -> result/done) used by the two-input CORDIC and adder tops.
- Buffers operand pairs in a small FIFO and issues them one at a time to a multicycle accelerator with a one-cycle start pulse.
- Waits for done, or for a timeout, then presents the result on a valid/ready output port.
- Sits between a host or test streamer and any ci-style accelerator.

Parameters:
- DEPTH, 4, operand FIFO entries (power of two, >=2)
- TIMEOUT, 1024, max cycles in WAIT before abort (>=2)
- TO_VALUE, 32'h7FC00000, result substituted on timeout (quiet NaN)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO not full
- in_dataa  in  32  operand A (IEEE-754 single)
- in_datab  in  32  operand B
- ci_start  out  1  one-cycle start pulse to accelerator
- ci_dataa  out  32  operand A to accelerator, registered
- ci_datab  out  32  operand B to accelerator, registered
- ci_result  in  32  accelerator result
- ci_done  in  1  accelerator completion
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  32  captured result or TO_VALUE
- out_timeout  out  1  qualifies out_result: 1 = aborted by timeout
- busy  out  1  FSM not in IDLE
- fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset, asynchronous and active-high: FSM=IDLE, FIFO empty, timer=0.
  - ci_start=0, ci_dataa/ci_datab=0.
  - out_valid=0, out_result=0, out_timeout=0, busy=0, fifo_count=0.
  - in_ready=1 after reset.
- Reset asserted mid-operation drops any in-flight op and all buffered entries; no output is produced for them.
- FIFO:
  - Push when in_valid & in_ready. in_ready = (fifo_count != DEPTH), derived from registered count.
  - Pop only in IDLE. Simultaneous push and pop keeps the count unchanged.
  - A push while full is ignored because in_ready=0.
  - Pointers wrap modulo DEPTH.
  - Data is first-in, first-out, and the A/B pairing is never split.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If FIFO is non-empty: pop, load head into ci_dataa/ci_datab, go to ISSUE.
  - An entry pushed at edge N can be popped in the cycle after edge N.
- ISSUE:
  - ci_start=1 for exactly this cycle; timer cleared to 0; go to WAIT.
  - ci_done is ignored in ISSUE.
- WAIT:
  - ci_dataa/ci_datab are held stable.
  - If ci_done=1: out_result<=ci_result, out_timeout<=0, go to HOLD.
  - Else if timer==TIMEOUT-1: out_result<=TO_VALUE, out_timeout<=1, go to HOLD.
  - Else timer<=timer+1.
  - If done and timeout occur in the same cycle, done wins.
- HOLD:
  - out_valid=1; out_result and out_timeout are stable.
  - On out_ready=1: out_valid drops next cycle and the FSM goes to IDLE.
  - ci_done is ignored.
- Minimum issue-to-issue spacing is 4 cycles plus accelerator latency (IDLE, ISSUE, WAIT>=1, HOLD>=1).
- ci_done is level-sampled in WAIT only. The accelerator must deassert done before the next ISSUE+1 cycle; a sticky done is accepted immediately on the next op. This is documented behaviour and is not flagged as an error.
- busy = (state != IDLE).
- Inputs are pushed freely while the FSM is busy, up to DEPTH.

Decomposition:
- Shared package ci_pkg holds:
  - FSM state enum {IDLE, ISSUE, WAIT, HOLD}
  - FP_QNAN = 32'h7FC00000
  - CI_WIDTH = 32
- One sub-module, ci_operand_fifo: parameterised DEPTH, 64-bit entries {a,b}, registered count, push/pop/full/empty.
- FSM, timer and output register stay in the top module.

Test Plan:
- Single op: push (3F800000, 40000000); stub accelerator asserts done for 1 cycle, 5 cycles after start, with result 40400000 -> exactly one ci_start pulse with ci_dataa=3F800000 and ci_datab=40000000; out_valid with out_result=40400000, out_timeout=0.
- Back-pressure: push 4 pairs with DEPTH=4 while out_ready=0 -> in_ready=0 once fifo_count=4; 5th push ignored; releasing out_ready drains results in push order; fifo_count returns to 0.
- Timeout: stub never asserts done, TIMEOUT=16 -> out_valid 16 cycles after the WAIT entry, with out_result=7FC00000 and out_timeout=1; the next queued op issues normally afterwards.
- Race: ci_done asserted on the final timeout cycle with result 3F800000 -> out_result=3F800000, out_timeout=0.
- Reset mid-WAIT with 2 entries queued -> all outputs return to reset values asynchronously; no out_valid, no further ci_start until a new push.
- Simultaneous push/pop: FIFO holds 1 entry, FSM in IDLE, push in the same cycle -> fifo_count stays 1; both ops complete in order.
